edge_pulse_gen: RTL and testbench
=================================

EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

Interface
REQ-001 Parameter HOLD_W, default 8: width of the hold-count field.
REQ-002 Parameter IDLE_LEVEL, default 1'b0: sig_out value after reset.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising clock edge.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command this cycle.
REQ-007 cmd_kind  input  2  RISE=0, FALL=1, TOGGLE=2, GLITCH=3.
REQ-008 cmd_hold  input  HOLD_W  cycles to hold sig_out after its change, unsigned.
REQ-009 sig_out  output  1  generated level waveform, registered.
REQ-010 edge_issued  output  1  one-cycle pulse in every cycle in which sig_out differs from its previous-cycle value.
REQ-011 err_redundant  output  1  one-cycle pulse when a RISE arrives with sig_out=1 or a FALL arrives with sig_out=0.
REQ-012 busy  output  1  equals NOT cmd_ready.

Function
REQ-013 Handshake: a command is accepted in cycle N when cmd_valid=1 and cmd_ready=1; cmd_kind and cmd_hold are captured in that cycle only.
REQ-014 cmd_ready is 1 only in state IDLE; cmd_valid may be held while cmd_ready=0 without effect.
REQ-015 FSM states: IDLE, HOLD, GLITCH_HI, GLITCH_HOLD.
REQ-016 RISE, FALL, and TOGGLE from IDLE: sig_out takes the target value in cycle N+1 (latency 1), and the FSM goes to HOLD with count=cmd_hold.
REQ-017 HOLD: count decrements once per cycle; at count=0 the FSM returns to IDLE, so cmd_ready=1 in cycle N+2+cmd_hold.
REQ-018 cmd_hold=0: cmd_ready is 0 for exactly one cycle (N+1) and returns to 1 in N+2.
REQ-019 Redundant RISE or FALL: sig_out is unchanged, err_redundant pulses in N+1, edge_issued stays 0, and the hold time still elapses (same ready timing as REQ-017).
REQ-020 GLITCH: sig_out inverts in N+1 and stays inverted for cmd_hold+1 cycles in GLITCH_HI; it restores in cycle N+2+cmd_hold.
REQ-021 After a GLITCH restore, the FSM enters GLITCH_HOLD for one cycle; cmd_ready=1 in N+3+cmd_hold.
REQ-022 GLITCH produces exactly two edge_issued pulses, in N+1 and N+2+cmd_hold.
REQ-023 The hold counter is HOLD_W bits, loads cmd_hold, and never wraps: decrement is inhibited at 0.
REQ-024 Maximum hold (all ones, 255 at default) gives 256 HOLD cycles with no overflow.
REQ-025 edge_issued is derived from a registered copy of sig_out; it never asserts in the cycle after reset deassertion.
REQ-026 err_redundant and edge_issued are never both 1 in the same cycle.

Reset
REQ-027 While reset=1, the next state is: sig_out=IDLE_LEVEL, FSM=IDLE, count=0, edge_issued=0, err_redundant=0, cmd_ready=1.
REQ-028 Reset during HOLD, GLITCH_HI, or GLITCH_HOLD aborts the operation: no restore edge is produced, and sig_out goes directly to IDLE_LEVEL.
REQ-029 A command presented in the same cycle as reset=1 is discarded.

Structure
REQ-030 Shared package edge_gen_pkg SHALL hold the cmd_kind enum (RISE/FALL/TOGGLE/GLITCH) and the FSM state enum; the RTL and the bench both import it.
REQ-031 The hold counter SHALL be a sub-module hold_counter, with load, decrement, and zero flag, parameterised by HOLD_W.
REQ-032 The output of this block SHALL be connectable directly to the existing edge detector input for loopback checking.

Verification
REQ-033 Bench SHALL cover: reset, then RISE hold=3 at cycle 2 -> sig_out=1 at cycle 3, edge_issued at cycle 3, cmd_ready=1 at cycle 7.
REQ-034 Bench SHALL cover: RISE hold=0 while sig_out=1 -> err_redundant at N+1, no edge_issued, cmd_ready=1 at N+2.
REQ-035 Bench SHALL cover: GLITCH hold=2 from sig_out=0 -> sig_out=1 for cycles N+1..N+3, back to 0 at N+4, two edge_issued pulses, cmd_ready=1 at N+5.
REQ-036 Bench SHALL cover: TOGGLE hold=255 -> cmd_ready low for 256 cycles, then high at N+257, with no counter wrap.
REQ-037 Bench SHALL cover: reset asserted mid-GLITCH_HI -> sig_out=0 the next cycle, cmd_ready=1, and no later restore edge.
REQ-038 Bench SHALL cover: loopback into the edge detector over 20 random commands -> detector rising/falling counts equal the edge_issued counts split by direction.

Source files
------------

// File: rtl/edge_gen_pkg.sv
// Shared types for the edge pulse generator: command kinds, FSM states and
// the redundant-command helper.
package edge_gen_pkg;

  typedef enum logic [1:0] {
    CmdRise   = 2'd0,
    CmdFall   = 2'd1,
    CmdToggle = 2'd2,
    CmdGlitch = 2'd3
  } cmd_kind_e;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StHold       = 2'd1,
    StGlitchHi   = 2'd2,
    StGlitchHold = 2'd3
  } gen_state_e;

  // A RISE onto a high line or a FALL onto a low line changes nothing.
  function automatic logic is_redundant(cmd_kind_e kind, logic level);
    return ((kind == CmdRise) && level) || ((kind == CmdFall) && !level);
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module hold_counter #(
  parameter int unsigned HOLD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [HOLD_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic [HOLD_W-1:0] count_o,
  output logic              zero_o
);

  logic [HOLD_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/edge_pulse_gen.sv
// Command-driven level generator: sets, clears, toggles or glitches sig_out and
// holds it for a programmable number of cycles before accepting the next command.
module edge_pulse_gen
  import edge_gen_pkg::*;
#(
  parameter int unsigned HOLD_W     = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              sig_out,
  output logic              edge_issued,
  output logic              err_redundant,
  output logic              busy
);

  gen_state_e        state_q, state_d;
  logic              sig_q, sig_d;
  logic              sig_prev_q;
  logic              err_q, err_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [HOLD_W-1:0] cnt_value;
  cmd_kind_e         kind;

  assign kind = cmd_kind_e'(cmd_kind);

  hold_counter #(
    .HOLD_W(HOLD_W)
  ) u_hold_counter (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (cnt_load),
    .load_val_i(cmd_hold),
    .dec_i     (cnt_dec),
    .count_o   (cnt_value),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cnt_load = 1'b1;
          err_d    = is_redundant(kind, sig_q);
          unique case (kind)
            CmdRise: begin
              sig_d   = 1'b1;
              state_d = StHold;
            end
            CmdFall: begin
              sig_d   = 1'b0;
              state_d = StHold;
            end
            CmdToggle: begin
              sig_d   = ~sig_q;
              state_d = StHold;
            end
            CmdGlitch: begin
              sig_d   = ~sig_q;
              state_d = StGlitchHi;
            end
          endcase
        end
      end
      StHold: begin
        if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StGlitchHi: begin
        // The glitch has lasted hold+1 cycles once the counter reaches zero.
        if (cnt_zero) begin
          sig_d   = ~sig_q;
          state_d = StGlitchHold;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StGlitchHold: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      sig_q      <= IDLE_LEVEL;
      sig_prev_q <= IDLE_LEVEL;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      sig_prev_q <= sig_q;
      err_q      <= err_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = ~cmd_ready;
  assign sig_out       = sig_q;
  // Reset loads both copies with the same level, so a reset never yields an edge.
  assign edge_issued   = sig_q ^ sig_prev_q;
  assign err_redundant = err_q;

  // cnt_value is kept visible for debug; the FSM only needs the zero flag.
  logic cnt_value_unused;
  assign cnt_value_unused = ^cnt_value;

  a_edge_err_exclusive: assert property (@(posedge clock) !(edge_issued && err_redundant));

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen with an in-bench edge detector for loopback.
module tb_edge_pulse_gen;
  import edge_gen_pkg::*;

  localparam int unsigned HoldW = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_kind;
  logic [HoldW-1:0] cmd_hold;
  logic             sig_out;
  logic             edge_issued;
  logic             err_redundant;
  logic             busy;

  int n_checks = 0;
  int n_err    = 0;

  // Loopback edge detector and issued-edge counters.
  logic det_prev = 1'b0;
  bit   mon_en   = 1'b0;
  int   det_rise = 0, det_fall = 0, iss_rise = 0, iss_fall = 0, excl_cnt = 0;

  always #5 clock = ~clock;

  edge_pulse_gen #(
    .HOLD_W    (HoldW),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_kind     (cmd_kind),
    .cmd_hold     (cmd_hold),
    .sig_out      (sig_out),
    .edge_issued  (edge_issued),
    .err_redundant(err_redundant),
    .busy         (busy)
  );

  always @(posedge clock) begin
    if (mon_en) begin
      if (sig_out && !det_prev) det_rise <= det_rise + 1;
      if (!sig_out && det_prev) det_fall <= det_fall + 1;
      if (edge_issued && sig_out) iss_rise <= iss_rise + 1;
      if (edge_issued && !sig_out) iss_fall <= iss_fall + 1;
    end
    if (edge_issued && err_redundant) excl_cnt <= excl_cnt + 1;
    det_prev <= sig_out;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one command once ready is high; bounded wait.
  task automatic issue(input cmd_kind_e kind, input int hold);
    for (int i = 0; i < 600 && !cmd_ready; i++) step();
    check_val("issue_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_kind  = kind;
    cmd_hold  = HoldW'(hold);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_sig [5];
    logic exp_rdy [5];
    logic exp_edg [5];
    int   low, edges, highs;
    logic level;
    int   exp_rise, exp_fall;
    cmd_kind_e k;

    reset = 1'b1; cmd_valid = 1'b0; cmd_kind = 2'd0; cmd_hold = '0;
    step(); step(); step();
    check_val("rst_sig", sig_out, 0);
    check_val("rst_ready", cmd_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_edge", edge_issued, 0);
    check_val("rst_err", err_redundant, 0);
    reset = 1'b0;
    step();
    check_val("post_rst_edge", edge_issued, 0);
    step();

    // RISE hold=3: sig high at N+1, ready returns at N+5.
    cmd_valid = 1'b1; cmd_kind = CmdRise; cmd_hold = 8'd3;
    check_val("rise_ready_n", cmd_ready, 1);
    step(); cmd_valid = 1'b0;
    check_val("rise_sig", sig_out, 1);
    check_val("rise_edge", edge_issued, 1);
    check_val("rise_busy", busy, 1);
    check_val("rise_err", err_redundant, 0);
    step();
    check_val("rise_edge_n2", edge_issued, 0);
    step(); step();
    check_val("rise_ready_n4", cmd_ready, 0);
    step();
    check_val("rise_ready_n5", cmd_ready, 1);

    // Redundant RISE hold=0; a held valid while busy must be ignored.
    cmd_valid = 1'b1; cmd_kind = CmdRise; cmd_hold = 8'd0;
    step();
    cmd_kind = CmdFall;
    check_val("red_rise_err", err_redundant, 1);
    check_val("red_rise_edge", edge_issued, 0);
    check_val("red_rise_sig", sig_out, 1);
    check_val("red_rise_ready_n1", cmd_ready, 0);
    step(); cmd_valid = 1'b0;
    check_val("red_rise_ready_n2", cmd_ready, 1);
    check_val("red_rise_held_sig", sig_out, 1);
    check_val("red_rise_err_n2", err_redundant, 0);

    // FALL hold=1 then redundant FALL hold=0.
    issue(CmdFall, 1);
    check_val("fall_sig", sig_out, 0);
    check_val("fall_edge", edge_issued, 1);
    check_val("fall_err", err_redundant, 0);
    step();
    check_val("fall_ready_n2", cmd_ready, 0);
    step();
    check_val("fall_ready_n3", cmd_ready, 1);
    issue(CmdFall, 0);
    check_val("red_fall_err", err_redundant, 1);
    check_val("red_fall_edge", edge_issued, 0);
    check_val("red_fall_sig", sig_out, 0);
    step();
    check_val("red_fall_ready", cmd_ready, 1);

    // GLITCH hold=2 from low: high N+1..N+3, low N+4, ready N+5.
    exp_sig = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_edg = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    issue(CmdGlitch, 2);
    edges = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      check_val($sformatf("glitch_sig_n%0d", i + 1), sig_out, exp_sig[i]);
      check_val($sformatf("glitch_ready_n%0d", i + 1), cmd_ready, exp_rdy[i]);
      check_val($sformatf("glitch_edge_n%0d", i + 1), edge_issued, exp_edg[i]);
      if (edge_issued) edges++;
    end
    check_val("glitch_edge_count", edges, 2);

    // TOGGLE hold=255: 256 busy cycles, ready at N+257.
    cmd_valid = 1'b1; cmd_kind = CmdToggle; cmd_hold = 8'd255;
    low = 0; edges = 0; highs = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      cmd_valid = 1'b0;
      if (cmd_ready) break;
      low++;
      if (edge_issued) edges++;
      if (sig_out) highs++;
    end
    check_val("toggle_busy_cycles", low, 256);
    check_val("toggle_edges", edges, 1);
    check_val("toggle_high_cycles", highs, 256);
    check_val("toggle_sig_end", sig_out, 1);

    // Reset in GLITCH_HI aborts the glitch with no restore edge.
    issue(CmdFall, 0);
    step();
    issue(CmdGlitch, 5);
    check_val("abort_sig_n1", sig_out, 1);
    step();
    reset = 1'b1;
    step();
    check_val("abort_sig", sig_out, 0);
    check_val("abort_ready", cmd_ready, 1);
    check_val("abort_edge", edge_issued, 0);
    // Command alongside reset is discarded.
    cmd_valid = 1'b1; cmd_kind = CmdRise; cmd_hold = 8'd0;
    step();
    check_val("rst_cmd_sig", sig_out, 0);
    check_val("rst_cmd_err", err_redundant, 0);
    reset = 1'b0; cmd_valid = 1'b0;
    edges = 0; highs = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (edge_issued) edges++;
      if (sig_out) highs++;
    end
    check_val("abort_late_edges", edges, 0);
    check_val("abort_late_high", highs, 0);

    // Loopback: 20 random commands, detector vs issued edges vs model.
    level = 1'b0; exp_rise = 0; exp_fall = 0;
    mon_en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      k = cmd_kind_e'($urandom_range(0, 3));
      case (k)
        CmdRise:   begin if (!level) exp_rise++; level = 1'b1; end
        CmdFall:   begin if (level) exp_fall++; level = 1'b0; end
        CmdToggle: begin if (level) exp_fall++; else exp_rise++; level = ~level; end
        default:   begin exp_rise++; exp_fall++; end
      endcase
      issue(k, int'($urandom_range(0, 4)));
    end
    for (int i = 0; i < 600 && !cmd_ready; i++) step();
    step(); step();
    mon_en = 1'b0;
    check_val("loop_det_rise", det_rise, iss_rise);
    check_val("loop_det_fall", det_fall, iss_fall);
    check_val("loop_model_rise", iss_rise, exp_rise);
    check_val("loop_model_fall", iss_fall, exp_fall);
    check_val("loop_final_sig", sig_out, level);
    check_val("edge_err_exclusive", excl_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
